// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, issues word reads to a synchronous program memory,
// and buffers returned instructions in a small FIFO feeding the decoder handshake.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_SIZE   = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [31:0]           if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] WRAP_L = (ADDR_WIDTH + 1)'(MEM_SIZE);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                  kill_q, kill_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [31:0]           hold_instr_q;
    logic [ADDR_WIDTH-1:0] hold_pc_q;

    logic [31:0]           instr_buf_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_buf_q    [FIFO_DEPTH];

    logic                  pop;
    logic                  push;
    logic                  not_empty;
    logic [CNT_W:0]        demand;

    function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc);
        logic [ADDR_WIDTH:0] inc;
        inc = {1'b0, pc} + {{ADDR_WIDTH{1'b0}}, 1'b1};
        if (inc == WRAP_L) begin
            return '0;
        end
        return inc[ADDR_WIDTH-1:0];
    endfunction

    assign not_empty = (count_q != '0);
    assign if_valid  = not_empty;
    assign pop       = if_valid & if_ready;
    assign push      = inflight_q & ~kill_q;

    // Slots already committed: buffered entries plus the response still in flight,
    // less the one leaving this cycle. Never request more than the FIFO can hold.
    assign demand    = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};

    // Gated by reset so no request escapes while reset is held low.
    assign imem_req  = reset & ~redirect & (demand < DEPTH_L);
    assign imem_addr = pc_q;

    // When empty, present whatever was shown last cycle so the outputs never go X.
    assign if_instr  = not_empty ? instr_buf_q[rd_ptr_q] : hold_instr_q;
    assign if_pc     = not_empty ? pc_buf_q[rd_ptr_q]    : hold_pc_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = imem_req;
        inflight_pc_d = pc_q;
        kill_d        = 1'b0;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect) begin
            pc_d     = redirect_pc;
            kill_d   = inflight_q;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (imem_req) begin
                pc_d = next_pc(pc_q);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            hold_instr_q  <= '0;
            hold_pc_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            hold_instr_q  <= if_instr;
            hold_pc_q     <= if_pc;
        end
    end

    // Buffer storage is only read while occupied, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push && !redirect) begin
            instr_buf_q[wr_ptr_q] <= imem_rdata;
            pc_buf_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: expected PCs are queued per scenario
// and consumed on every decoder handshake; program memory word[i] = i.
module tb_instruction_fetch_unit;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata = 32'h0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          if_valid;
    logic          if_ready = 1'b0;
    logic [31:0]   if_instr;
    logic [AW-1:0] if_pc;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_q[$];

    instruction_fetch_unit #(.ADDR_WIDTH(AW), .MEM_SIZE(128), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    // Synchronous program memory model, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= {25'b0, imem_addr};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0; if_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        #1 reset = 1'b0;
        if_ready = 1'b1;
        #2;
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b expected 0", imem_req); end
        n_cmp++; if (imem_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %0h expected 0", imem_addr); end
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", if_valid); end
        n_cmp++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %0h expected 0", if_instr); end
        n_cmp++; if (if_pc !== '0) begin n_fail++; $display("FAIL rst_pc: got %0h expected 0", if_pc); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req_held: got %0b expected 0", imem_req); end
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid_held: got %0b expected 0", if_valid); end
    endtask

    task automatic test_stream;
        int first_valid;
        logic [AW-1:0] e;
        do_reset();
        if_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(i);
        first_valid = -1;
        for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
            #1;
            if (cyc == 0) begin
                n_cmp++;
                if (imem_req !== 1'b1 || imem_addr !== '0) begin
                    n_fail++; $display("FAIL stream_first_req: got req=%0b addr=%0h expected req=1 addr=0", imem_req, imem_addr);
                end
            end
            if (first_valid >= 0) begin
                n_cmp++;
                if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stream_gap: cycle %0d valid=%0b expected 1", cyc, if_valid); end
            end
            if (if_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                e = AW'(exp_q.pop_front());
                n_cmp++; if (if_pc !== e) begin n_fail++; $display("FAIL stream_pc: got %0h expected %0h", if_pc, e); end
                n_cmp++; if (if_instr !== {25'b0, e}) begin n_fail++; $display("FAIL stream_instr: got %0h expected %0h", if_instr, {25'b0, e}); end
            end
            tick();
        end
        n_cmp++; if (first_valid != 2) begin n_fail++; $display("FAIL stream_latency: first valid cycle %0d expected 2", first_valid); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_drain: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure;
        int nreq;
        logic [AW-1:0] e;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(i);
        nreq = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (imem_req === 1'b1) begin
                n_cmp++;
                if (imem_addr !== AW'(nreq)) begin n_fail++; $display("FAIL bp_addr: got %0h expected %0h", imem_addr, nreq); end
                nreq++;
            end
            if (if_valid === 1'b1) begin
                n_cmp++; if (if_pc !== '0) begin n_fail++; $display("FAIL bp_hold: got pc %0h expected 0", if_pc); end
            end
            tick();
        end
        n_cmp++; if (nreq != 4) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 4", nreq); end
        if_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && exp_q.size() != 0; cyc++) begin
            #1;
            n_cmp++;
            if (if_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_gap: cycle %0d valid=%0b expected 1", cyc, if_valid);
            end else begin
                e = AW'(exp_q.pop_front());
                n_cmp++; if (if_pc !== e) begin n_fail++; $display("FAIL bp_pc: got %0h expected %0h", if_pc, e); end
                n_cmp++; if (if_instr !== {25'b0, e}) begin n_fail++; $display("FAIL bp_instr: got %0h expected %0h", if_instr, {25'b0, e}); end
            end
            tick();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect_full;
        logic [AW-1:0] e;
        do_reset();
        repeat (4) tick();
        // Three buffered entries plus one response in flight.
        redirect = 1'b1; redirect_pc = AW'(7'h40);
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rdf_req_n: got %0b expected 0", imem_req); end
        tick();
        redirect = 1'b0; if_ready = 1'b1;
        #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rdf_valid_n1: got %0b expected 0", if_valid); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== AW'(7'h40)) begin
            n_fail++; $display("FAIL rdf_req_n1: got req=%0b addr=%0h expected req=1 addr=40", imem_req, imem_addr);
        end
        tick();
        #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rdf_valid_n2: got %0b expected 0", if_valid); end
        tick();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h40 + i);
        for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
            #1;
            n_cmp++;
            if (if_valid !== 1'b1) begin
                n_fail++; $display("FAIL rdf_valid: cycle N+%0d valid=%0b expected 1", cyc + 3, if_valid);
            end else begin
                e = AW'(exp_q.pop_front());
                n_cmp++; if (if_pc !== e) begin n_fail++; $display("FAIL rdf_pc: got %0h expected %0h", if_pc, e); end
            end
            tick();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rdf_drain: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] e;
        do_reset();
        if_ready = 1'b1;
        redirect = 1'b1; redirect_pc = AW'(126);
        tick();
        redirect = 1'b0;
        exp_q.delete();
        exp_q.push_back(126); exp_q.push_back(127); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
            #1;
            if (if_valid === 1'b1) begin
                e = AW'(exp_q.pop_front());
                n_cmp++; if (if_pc !== e) begin n_fail++; $display("FAIL wrap_pc: got %0h expected %0h", if_pc, e); end
                n_cmp++; if (if_instr !== {25'b0, e}) begin n_fail++; $display("FAIL wrap_instr: got %0h expected %0h", if_instr, {25'b0, e}); end
            end
            tick();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_drain: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect_handshake_and_reset;
        logic [AW-1:0] e;
        bit done;
        int first_valid;
        do_reset();
        if_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i <= 5; i++) exp_q.push_back(i);
        exp_q.push_back(20); exp_q.push_back(21); exp_q.push_back(22);
        done = 1'b0;
        for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
            redirect = 1'b0;
            #1;
            if (!done && if_valid === 1'b1 && if_pc === AW'(5)) begin
                redirect = 1'b1; redirect_pc = AW'(20); done = 1'b1;
            end
            if (if_valid === 1'b1) begin
                e = AW'(exp_q.pop_front());
                n_cmp++; if (if_pc !== e) begin n_fail++; $display("FAIL rdh_pc: got %0h expected %0h", if_pc, e); end
            end
            tick();
        end
        redirect = 1'b0;
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rdh_drain: %0d left expected 0", exp_q.size()); end

        // Reset pulse shorter than a clock period, mid-stream.
        reset = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mrst_req: got %0b expected 0", imem_req); end
        n_cmp++; if (imem_addr !== '0) begin n_fail++; $display("FAIL mrst_addr: got %0h expected 0", imem_addr); end
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %0b expected 0", if_valid); end
        n_cmp++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL mrst_instr: got %0h expected 0", if_instr); end
        n_cmp++; if (if_pc !== '0) begin n_fail++; $display("FAIL mrst_pc: got %0h expected 0", if_pc); end
        #1 reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        first_valid = -1;
        for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
            #1;
            if (cyc == 0) begin
                n_cmp++;
                if (imem_req !== 1'b1 || imem_addr !== '0) begin
                    n_fail++; $display("FAIL mrst_restart: got req=%0b addr=%0h expected req=1 addr=0", imem_req, imem_addr);
                end
            end
            if (if_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                e = AW'(exp_q.pop_front());
                n_cmp++; if (if_pc !== e) begin n_fail++; $display("FAIL mrst_pc_seq: got %0h expected %0h", if_pc, e); end
            end
            tick();
        end
        n_cmp++; if (first_valid != 2) begin n_fail++; $display("FAIL mrst_latency: first valid cycle %0d expected 2", first_valid); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mrst_drain: %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_wrap();
        test_redirect_handshake_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end fetch stage of the RISC-V core. It owns the program counter and issues word-address reads to the synchronous `program_memory`. It buffers returned instructions in a small FIFO and hands them to `instruction_decoder` over a valid/ready handshake. It absorbs decode back-pressure and supports a single-cycle redirect (branch/jump target) that flushes all fetched-but-unconsumed instructions.

## Interface
- `ADDR_WIDTH`, default 7: width of the instruction word address.
- `MEM_SIZE`, default 128: number of instruction words; PC wraps modulo `MEM_SIZE`.
- `FIFO_DEPTH`, default 4: instruction buffer entries; power of two, minimum 2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `imem_req`  out  1  read strobe to program memory.
- `imem_addr`  out  ADDR_WIDTH  word address of the read.
- `imem_rdata`  in  32  instruction word, valid exactly one cycle after `imem_req`.
- `redirect`  in  1  one-cycle pulse: flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  ADDR_WIDTH  restart address.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a valid instruction.
- `if_ready`  in  1  decoder accepts the instruction this cycle.
- `if_instr`  out  32  instruction at FIFO head.
- `if_pc`  out  ADDR_WIDTH  address of `if_instr`.

## Operation
- State:
  - `pc` (next address to request).
  - `inflight` flag (request issued last cycle).
  - `inflight_pc`.
  - `kill` flag.
  - FIFO of {instr, pc} pairs with read/write pointers and an occupancy counter (0..`FIFO_DEPTH`).
- Reset (reset=0), asynchronous and overriding everything:
  - `pc`=0, `inflight`=0, `kill`=0, occupancy=0, pointers=0.
  - Outputs: `imem_req`=0, `imem_addr`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0.
- Pop: `if_valid && if_ready`. Head entry is removed at the clock edge.
- Issue rule: `imem_req` = !`redirect` && (occupancy + `inflight` − pop) < `FIFO_DEPTH`. This is combinational from registered state and the current `if_ready`.
  - When issuing, `imem_addr`=`pc`; on the edge, `pc` ← (`pc`+1 == `MEM_SIZE`) ? 0 : `pc`+1.
  - `inflight` ← `imem_req` and `inflight_pc` ← `pc`.
- Response: in a cycle with `inflight`=1 and `kill`=0, {`imem_rdata`, `inflight_pc`} is written to the FIFO tail. The issue rule guarantees the FIFO never overflows.
  - Simultaneous push and pop is legal, and occupancy is unchanged.
- Redirect (`redirect`=1 in cycle N):
  - A handshake (pop) occurring in cycle N is honoured; the consumer owns that instruction.
  - At the edge ending N: occupancy ← 0, pointers ← 0, `pc` ← `redirect_pc`, `kill` ← `inflight`.
  - No request is issued in cycle N.
  - Cycle N+1: `if_valid`=0. Any response arriving is dropped (`kill`). A request for `redirect_pc` is issued. `kill` then clears.
  - A redirect in N+1 again is legal and restarts the same sequence.
- Empty: `if_valid`=0, and `if_instr`/`if_pc` retain their last values (not X).
- `if_valid`, `if_instr`, `if_pc` must not change while `if_valid`=1 and `if_ready`=0, except on redirect or reset.

## Timing
- Request-to-output latency: request in cycle N; data registered into the FIFO at the end of N+1; `if_valid`=1 in N+2. There is no bypass path.
- First fetch after reset deassertion: `imem_req`=1, `imem_addr`=0 in the first cycle; `if_valid` rises two cycles later.
- Steady-state throughput: 1 instruction/cycle with `if_ready` held 1.
- Redirect-to-first-valid: redirect in N; `if_valid` for `redirect_pc` in N+3.
- Back-pressure: with `if_ready`=0, requests stop once occupancy + inflight = `FIFO_DEPTH`. No instruction is lost or duplicated.
- Wrap: address `MEM_SIZE`−1 is followed by 0 (127 → 0 at defaults).
- Reset asserted mid-stream: all state clears immediately, without waiting for a clock edge. Any response arriving after deassertion without a matching post-reset request is ignored.

## Test plan
- Reset, then `if_ready`=1 with memory word[i]=i: `if_valid` is first 1 on the 3rd cycle after deassertion with `if_pc`=0, `if_instr`=0. The outputs then increment by 1 every cycle.
- Hold `if_ready`=0 from cycle 0: exactly 4 requests are issued (addresses 0–3) and `imem_req` then stays 0. Release `if_ready`: PCs 0,1,2,3,4,… are delivered with no gap and no duplicate.
- Pulse `redirect` with `redirect_pc`=0x40 while the FIFO is full and a request is inflight: `if_valid`=0 in the next cycle. The next delivered `if_pc`=0x40 arrives exactly 3 cycles after the pulse, and no stale PC appears.
- Start at `redirect_pc`=126 with `if_ready`=1: delivered PCs are 126, 127, 0, 1.
- Assert `redirect` in the same cycle as a handshake on PC 5 with `redirect_pc`=20: PC 5 is consumed once and the next delivered PC is 20. Then assert `reset`=0 mid-stream for a partial cycle: all outputs go to 0 immediately, and fetch restarts from 0.
